tick_timer: RTL and testbench

TICK_TIMER -- requirements
Module: tick_timer

---
 rtl/tick_timer_pkg.sv | 17 +
 rtl/tick_prescaler.sv | 42 ++++
 rtl/tick_timer.sv | 165 ++++++++++++++++
 tb/tb_tick_timer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tick_timer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_timer_pkg : shared FSM state type and default widths for tick_timer
// Rev 1.0
// ---------------------------------------------------------------------------
package tick_timer_pkg;

  localparam int unsigned C_DEF_WIDTH     = 16;
  localparam int unsigned C_DEF_PRE_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : tick_timer_pkg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_prescaler : divides the run clock by (pre_i + 1), emitting tick_o
// Rev 1.0
// ---------------------------------------------------------------------------
module tick_prescaler
  import tick_timer_pkg::*;
#(
  parameter int unsigned PRE_WIDTH = C_DEF_PRE_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_i,
  input  logic [PRE_WIDTH-1:0] pre_i,
  output logic                 tick_o
);

  logic [PRE_WIDTH-1:0] cnt_q;
  logic [PRE_WIDTH-1:0] cnt_d;

  assign tick_o = (cnt_q == pre_i);

  // Held at zero outside RUN so every run starts on a fresh division phase.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/tick_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_timer : compare timer, IDLE/RUN FSM, shadowed config while running.
// Define TICK_TIMER_PRESCALE_EN to add cfg_pre and the prescaler. Rev 1.0
// ---------------------------------------------------------------------------
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int unsigned WIDTH     = C_DEF_WIDTH,
  parameter int unsigned PRE_WIDTH = C_DEF_PRE_WIDTH
) (
  input  logic                 mclk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [WIDTH-1:0]     cfg_cmp,
  input  logic                 cfg_oneshot,
`ifdef TICK_TIMER_PRESCALE_EN
  input  logic [PRE_WIDTH-1:0] cfg_pre,
`endif
  output logic                 equal,
  output logic                 busy,
  output logic [WIDTH-1:0]     count
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               equal_q, equal_d;
  logic [WIDTH-1:0]   cmp_q, cmp_d;
  logic               oneshot_q, oneshot_d;
  logic               pend_q, pend_d;
  logic [WIDTH-1:0]   sh_cmp_q, sh_cmp_d;
  logic               sh_oneshot_q, sh_oneshot_d;
  logic               xfer_w;
  logic               tick_w;
  logic               promote_w;

`ifdef TICK_TIMER_PRESCALE_EN
  logic [PRE_WIDTH-1:0] pre_q, pre_d;
  logic [PRE_WIDTH-1:0] sh_pre_q, sh_pre_d;

  tick_prescaler #(
    .PRE_WIDTH (PRE_WIDTH)
  ) u_prescaler (
    .clk    (mclk),
    .rst    (rst),
    .run_i  (state_q == RUN),
    .pre_i  (pre_q),
    .tick_o (tick_w)
  );
`else
  assign tick_w = 1'b1;
`endif

  assign cfg_ready = (state_q == IDLE) || !pend_q;
  assign xfer_w    = cfg_valid && cfg_ready;
  assign busy      = (state_q == RUN);
  assign equal     = equal_q;
  assign count     = count_q;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    equal_d      = 1'b0;
    cmp_d        = cmp_q;
    oneshot_d    = oneshot_q;
    pend_d       = pend_q;
    sh_cmp_d     = sh_cmp_q;
    sh_oneshot_d = sh_oneshot_q;
    promote_w    = 1'b0;
`ifdef TICK_TIMER_PRESCALE_EN
    pre_d        = pre_q;
    sh_pre_d     = sh_pre_q;
`endif

    case (state_q)
      IDLE: begin
        if (xfer_w) begin
          cmp_d     = cfg_cmp;
          oneshot_d = cfg_oneshot;
`ifdef TICK_TIMER_PRESCALE_EN
          pre_d     = cfg_pre;
`endif
        end
        if (start && !stop) begin
          state_d = RUN;
          count_d = '0;
        end
      end

      RUN: begin
        if (xfer_w) begin
          sh_cmp_d     = cfg_cmp;
          sh_oneshot_d = cfg_oneshot;
`ifdef TICK_TIMER_PRESCALE_EN
          sh_pre_d     = cfg_pre;
`endif
          pend_d       = 1'b1;
        end
        if (stop) begin
          state_d   = IDLE;
          count_d   = '0;
          promote_w = 1'b1;
        end else if (tick_w) begin
          if (count_q == cmp_q) begin
            equal_d   = 1'b1;
            count_d   = '0;
            promote_w = 1'b1;
            if (oneshot_q) begin
              state_d = IDLE;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // A shadow written on this same edge is promoted straight through.
    if (promote_w && pend_d) begin
      cmp_d     = sh_cmp_d;
      oneshot_d = sh_oneshot_d;
`ifdef TICK_TIMER_PRESCALE_EN
      pre_d     = sh_pre_d;
`endif
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      equal_q      <= 1'b0;
      cmp_q        <= '1;
      oneshot_q    <= 1'b0;
      pend_q       <= 1'b0;
      sh_cmp_q     <= '0;
      sh_oneshot_q <= 1'b0;
`ifdef TICK_TIMER_PRESCALE_EN
      pre_q        <= '0;
      sh_pre_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      equal_q      <= equal_d;
      cmp_q        <= cmp_d;
      oneshot_q    <= oneshot_d;
      pend_q       <= pend_d;
      sh_cmp_q     <= sh_cmp_d;
      sh_oneshot_q <= sh_oneshot_d;
`ifdef TICK_TIMER_PRESCALE_EN
      pre_q        <= pre_d;
      sh_pre_q     <= sh_pre_d;
`endif
    end
  end

endmodule : tick_timer
`default_nettype wire

// File: tb/tb_tick_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tick_timer : randomized and directed self-checking bench for tick_timer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_tick_timer;

  localparam int W  = 16;
  localparam int PW = 8;

  logic          mclk        = 1'b0;
  logic          rst         = 1'b0;
  logic          start       = 1'b0;
  logic          stop        = 1'b0;
  logic          cfg_valid   = 1'b0;
  logic          cfg_oneshot = 1'b0;
  logic [W-1:0]  cfg_cmp     = '0;
  logic [PW-1:0] cfg_pre     = '0;
  logic          cfg_ready;
  logic          equal;
  logic          busy;
  logic [W-1:0]  count;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  tick_timer #(
    .WIDTH     (W),
    .PRE_WIDTH (PW)
  ) dut (
    .mclk        (mclk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_cmp     (cfg_cmp),
    .cfg_oneshot (cfg_oneshot),
`ifdef TICK_TIMER_PRESCALE_EN
    .cfg_pre     (cfg_pre),
`endif
    .equal       (equal),
    .busy        (busy),
    .count       (count)
  );

  always #5 mclk = ~mclk;

  // Reference: position m_k counts clock cycles into the current period of
  // (cmp+1)*(pre+1) cycles; the visible count is m_k / (pre+1).
  bit              m_run, m_one, m_pend, m_eq, s_one, m_xfer, m_roll;
  logic [W-1:0]    m_cmp, s_cmp;
  longint unsigned m_pre, s_pre, m_k, m_per;

  function automatic bit m_ready();
    return !m_run || !m_pend;
  endfunction

  function automatic logic [W-1:0] m_count();
    return W'(m_k / (m_pre + 1));
  endfunction

  function automatic longint unsigned pre_in();
`ifdef TICK_TIMER_PRESCALE_EN
    return longint'(cfg_pre);
`else
    return 0;
`endif
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  always @(posedge mclk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_one = 0; m_pend = 0; m_eq = 0;
      m_cmp = '1; m_pre = 0; m_k = 0;
    end else begin
      m_xfer = cfg_valid && m_ready();
      m_eq   = 0;
      m_roll = 0;
      if (!m_run) begin
        if (m_xfer) begin
          m_cmp = cfg_cmp; m_one = cfg_oneshot; m_pre = pre_in();
        end
        if (start && !stop) begin
          m_run = 1; m_k = 0;
        end
      end else begin
        if (m_xfer) begin
          s_cmp = cfg_cmp; s_one = cfg_oneshot; s_pre = pre_in(); m_pend = 1;
        end
        m_per = (longint'(m_cmp) + 1) * (m_pre + 1);
        if (stop) begin
          m_run = 0; m_k = 0; m_roll = 1;
        end else if (m_k == m_per - 1) begin
          m_eq = 1; m_k = 0; m_roll = 1;
          if (m_one) m_run = 0;
        end else begin
          m_k++;
        end
        if (m_roll && m_pend) begin
          m_cmp = s_cmp; m_one = s_one; m_pre = s_pre; m_pend = 0;
        end
      end
    end
  end

  always @(negedge mclk) begin
    if (chk_en) begin
      chk("count", count, m_count());
      chk("equal", equal, m_eq);
      chk("busy", busy, m_run);
      chk("cfg_ready", cfg_ready, m_ready());
    end
  end

  task automatic cfg(input int cmp, input bit one, input int pre);
    cfg_valid = 1; cfg_cmp = W'(cmp); cfg_oneshot = one; cfg_pre = PW'(pre);
    @(negedge mclk);
    cfg_valid = 0;
  endtask

  initial begin
    int cnt_tab[13] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 0, 1, 0};
    int eq_tab[13]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1};
    int rdy_tab[13] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};

    #1 rst = 1;
    @(negedge mclk);
    chk_en = 1;
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_equal", equal, 0);
    chk("rst_ready", cfg_ready, 1);
    #2 rst = 0;
    @(negedge mclk);

    // Periodic cmp=3, then a shadow load of cmp=1 mid-run.
    cfg(3, 0, 0);
    for (int i = 0; i < 13; i++) begin
      start     = (i == 0);
      cfg_valid = (i == 6);
      cfg_cmp   = 1;
      @(negedge mclk);
      chk("per_count", count, cnt_tab[i]);
      chk("per_equal", equal, eq_tab[i]);
      chk("per_ready", cfg_ready, rdy_tab[i]);
      chk("model_count", m_count(), cnt_tab[i]);
    end
    start = 0; cfg_valid = 0; stop = 1;
    @(negedge mclk);
    stop = 0;
    chk("stop_busy", busy, 0);

    // One-shot cmp=5: single pulse six cycles after the start edge.
    cfg(5, 1, 0);
    for (int i = 0; i < 8; i++) begin
      start = (i == 0);
      @(negedge mclk);
      chk("os_equal", equal, (i == 6));
      chk("os_busy", busy, (i < 6));
    end

    // Start and stop together while idle.
    start = 1; stop = 1;
    @(negedge mclk);
    start = 0; stop = 0;
    chk("ss_busy", busy, 0);
    chk("ss_equal", equal, 0);
    @(negedge mclk);
    chk("ss_busy2", busy, 0);

    // Reset mid-run at count=2 with a shadow pending.
    cfg(5, 0, 0);
    start = 1;
    @(negedge mclk);
    start = 0; cfg_valid = 1; cfg_cmp = 2;
    @(negedge mclk);
    cfg_valid = 0;
    @(negedge mclk);
    chk("mid_count", count, 2);
    chk("mid_ready", cfg_ready, 0);
    #2 rst = 1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_equal", equal, 0);
    chk("arst_ready", cfg_ready, 1);
    #1 rst = 0;
    start = 1;
    @(negedge mclk);
    start = 0;
    chk("first_start_busy", busy, 1);
    stop = 1;
    @(negedge mclk);
    stop = 0;

`ifdef TICK_TIMER_PRESCALE_EN
    cfg(1, 0, 3);
    for (int i = 0; i < 17; i++) begin
      start = (i == 0);
      @(negedge mclk);
      chk("pre_equal", equal, (i > 0 && i % 8 == 0));
    end
    stop = 1;
    @(negedge mclk);
    stop = 0;
`endif

    for (int c = 0; c < 3000; c++) begin
      start       = ($urandom_range(0, 7) == 0);
      stop        = ($urandom_range(0, 39) == 0);
      cfg_valid   = ($urandom_range(0, 5) == 0);
      cfg_cmp     = ($urandom_range(0, 15) == 0) ? W'($urandom_range(0, 40))
                                                 : W'($urandom_range(0, 5));
      cfg_oneshot = ($urandom_range(0, 2) == 0);
      cfg_pre     = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1;
        #2 rst = 0;
      end
      @(negedge mclk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_tick_timer
`default_nettype wire
